ssd_frame_decoder: RTL and testbench

SSD_FRAME_DECODER -- requirements
Module: ssd_frame_decoder

---
 rtl/ssd_pkg.sv | 34 +++
 rtl/ssd_glyph_decode.sv | 25 ++
 rtl/ssd_frame_decoder.sv | 138 +++++++++++++
 tb/tb_ssd_frame_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared glyph codes, seven-segment patterns (active-low, bit6=g .. bit0=a)
// and the frame FSM state type.
package ssd_pkg;

  localparam logic [4:0] GLYPH_BLANK = 5'h10;
  localparam logic [4:0] GLYPH_L     = 5'h11;
  localparam logic [4:0] GLYPH_U     = 5'h12;
  localparam logic [4:0] GLYPH_N     = 5'h13;
  localparam logic [4:0] GLYPH_P     = 5'h14;
  localparam logic [4:0] GLYPH_BAD   = 5'h1F;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  // Entry i holds the pattern of hex digit i (F is the leftmost element).
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam logic [19:0] FRAME_BLANK = {4{GLYPH_BLANK}};

  typedef enum logic [1:0] {
    ST_DARK,
    ST_COLLECT,
    ST_PUBLISH
  } state_e;

endpackage

// File: rtl/ssd_glyph_decode.sv
// Combinational lookup from an active-low cathode pattern to a 5-bit glyph code.
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [4:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_BAD;
    case (seg_i)
      SEG_BLANK: glyph_o = GLYPH_BLANK;
      SEG_L:     glyph_o = GLYPH_L;
      SEG_U:     glyph_o = GLYPH_U;
      SEG_N:     glyph_o = GLYPH_N;
      SEG_P:     glyph_o = GLYPH_P;
      default:   ;
    endcase
    // Hex matches are applied last so they override any letter reading.
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_HEX[i]) glyph_o = 5'(i);
    end
  end

endmodule

// File: rtl/ssd_frame_decoder.sv
// Recovers the four displayed glyphs from a multiplexed seven-segment drive:
// debounce each slot, collect all four, publish a frame or declare the display dark.
module ssd_frame_decoder
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anodes,
  input  logic [6:0]  cathodes,
  output logic [19:0] glyphs,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        dark,
  output logic        mux_error
);

  localparam int SW = $clog2(STABLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STB_ACCEPT = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STB_SAT    = SW'(STABLE_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [10:0]   sample_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    mask_q, mask_d;
  logic [19:0]   pend_q, pend_d;
  logic [19:0]   glyphs_q, glyphs_d;
  logic          chg_q, chg_d;
  logic          dark_q, dark_d;
  logic          mux_err_q, mux_err_d;

  logic [3:0]    slot_oh;
  logic [4:0]    glyph;
  logic          accept, slot_hit, multi_hit;

  ssd_glyph_decode u_decode (
    .seg_i   (sample_q[6:0]),
    .glyph_o (glyph)
  );

  // slot_oh[s] is high when the anode of slot s (slot0 = anodes[3]) is driven.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign slot_oh[gi] = ~sample_q[10-gi];
    end
  endgenerate

  assign accept    = (stab_q == STB_ACCEPT);
  assign slot_hit  = accept && ($countones(slot_oh) == 1);
  assign multi_hit = accept && ($countones(slot_oh) > 1);

  // Saturating one past the accept value keeps a long run from re-accepting.
  always_comb begin
    if ({anodes, cathodes} != sample_q) stab_d = SW'(1);
    else if (stab_q == STB_SAT)         stab_d = stab_q;
    else                                stab_d = stab_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    glyphs_d  = glyphs_q;
    chg_d     = 1'b0;
    dark_d    = dark_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    mux_err_d = multi_hit;

    if (slot_hit)             tmo_d = '0;
    else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
    else                      tmo_d = tmo_q + 1'b1;

    case (state_q)
      ST_DARK, ST_COLLECT: begin
        if (mask_q == 4'b1111) begin
          state_d  = ST_PUBLISH;
          glyphs_d = pend_q;
          chg_d    = (pend_q != glyphs_q);
          dark_d   = 1'b0;
          mask_d   = '0;
        end else if (state_q == ST_COLLECT && tmo_q == TMO_MAX) begin
          state_d  = ST_DARK;
          glyphs_d = FRAME_BLANK;
          dark_d   = 1'b1;
          mask_d   = '0;
        end
      end
      ST_PUBLISH: state_d = ST_COLLECT;
      default:    state_d = ST_DARK;
    endcase

    // A new slot accept lands on top of any mask clear made above.
    for (int s = 0; s < 4; s++) begin
      if (slot_hit && slot_oh[s]) begin
        pend_d[(3-s)*5 +: 5] = glyph;
        mask_d[s]            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DARK;
      sample_q  <= 11'h7FF;
      stab_q    <= '0;
      tmo_q     <= '0;
      mask_q    <= '0;
      pend_q    <= FRAME_BLANK;
      glyphs_q  <= FRAME_BLANK;
      chg_q     <= 1'b0;
      dark_q    <= 1'b1;
      mux_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= {anodes, cathodes};
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      glyphs_q  <= glyphs_d;
      chg_q     <= chg_d;
      dark_q    <= dark_d;
      mux_err_q <= mux_err_d;
    end
  end

  assign glyphs        = glyphs_q;
  assign frame_valid   = (state_q == ST_PUBLISH);
  assign frame_changed = chg_q;
  assign dark          = dark_q;
  assign mux_error     = mux_err_q;

endmodule

// File: tb/tb_ssd_frame_decoder.sv
// Self-checking bench: drives held input segments and compares observed frames,
// mux errors and dark behaviour against an event-level model of the display rules.
module tb_ssd_frame_decoder;

  localparam int S = 16;
  localparam int T = 500;
  localparam logic [19:0] BLANK4 = 20'h84210;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;
  logic [19:0] glyphs;
  logic        frame_valid, frame_changed, dark, mux_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  ssd_frame_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .anodes        (anodes),
    .cathodes      (cathodes),
    .glyphs        (glyphs),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .dark          (dark),
    .mux_error     (mux_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] hex_seg [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [6:0] letter_seg [5] = '{
    7'b1111111, 7'b1000111, 7'b1000001, 7'b0101011, 7'b0001100
  };

  // Reference model state
  logic [4:0]  m_pend [4];
  bit          m_seen [4];
  logic [19:0] m_prev;
  int          m_mux;
  logic [19:0] exp_g [$];
  bit          exp_c [$];

  // Observations
  logic [19:0] obs_g [$];
  bit          obs_c [$];
  int          obs_t [$];
  int          obs_mux;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_valid) begin
        obs_g.push_back(glyphs);
        obs_c.push_back(frame_changed);
        obs_t.push_back(cyc);
      end
      if (mux_error) obs_mux++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] ref_glyph(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) if (seg == hex_seg[i]) return 5'(i);
    case (seg)
      7'b1111111: return 5'h10;
      7'b1000111: return 5'h11;
      7'b1000001: return 5'h12;
      7'b0101011: return 5'h13;
      7'b0001100: return 5'h14;
      default:    return 5'h1F;
    endcase
  endfunction

  function automatic logic [3:0] slot_an(input int s);
    logic [3:0] v;
    v = 4'b1000;
    return ~(v >> s);
  endfunction

  function automatic logic [6:0] rand_seg();
    case ($urandom_range(0, 3))
      0, 1:    return hex_seg[$urandom_range(0, 15)];
      2:       return letter_seg[$urandom_range(0, 4)];
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_seen[s] = 1'b0;
    m_prev = BLANK4;
  endtask

  task automatic clear_obs();
    obs_g.delete(); obs_c.delete(); obs_t.delete();
    exp_g.delete(); exp_c.delete();
    obs_mux = 0;
    m_mux = 0;
  endtask

  // Applies one input value for `hold` clock edges and updates the model.
  task automatic drive_seg(input logic [3:0] a, input logic [6:0] c, input int hold);
    logic [3:0]  na;
    logic [19:0] frame;
    int          slot;
    bit          all_seen;
    anodes   = a;
    cathodes = c;
    na = ~a;
    if (hold >= S && na != 4'b0000) begin
      if ($countones(na) == 1) begin
        slot = 0;
        for (int s = 0; s < 4; s++) if (na[3-s]) slot = s;
        m_pend[slot] = ref_glyph(c);
        m_seen[slot] = 1'b1;
        all_seen = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
        if (all_seen) begin
          frame = {m_pend[0], m_pend[1], m_pend[2], m_pend[3]};
          exp_g.push_back(frame);
          exp_c.push_back(frame != m_prev);
          m_prev = frame;
          for (int s = 0; s < 4; s++) m_seen[s] = 1'b0;
        end
      end else begin
        m_mux++;
      end
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input int hold);
    drive_seg(slot_an(0), s0, hold);
    drive_seg(slot_an(1), s1, hold);
    drive_seg(slot_an(2), s2, hold);
    drive_seg(slot_an(3), s3, hold);
  endtask

  task automatic settle();
    drive_seg(4'hF, 7'h7F, 6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; anodes = 4'hF; cathodes = 7'h7F;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (glyphs !== BLANK4) begin errors++; $display("FAIL reset_glyphs: got %h want %h", glyphs, BLANK4); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    checks++; if (frame_changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b want 0", frame_changed); end
    checks++; if (dark !== 1'b1) begin errors++; $display("FAIL reset_dark: got %b want 1", dark); end
    checks++; if (mux_error !== 1'b0) begin errors++; $display("FAIL reset_mux: got %b want 0", mux_error); end
    rst_n = 1'b1;
    model_reset();
    clear_obs();
    drive_seg(4'hF, 7'h7F, 30);
    checks++; if (obs_g.size() !== 0) begin errors++; $display("FAIL reset_idle_frames: got %0d want 0", obs_g.size()); end
    checks++; if (dark !== 1'b1) begin errors++; $display("FAIL reset_idle_dark: got %b want 1", dark); end
    $display("test_reset: done");
  endtask

  task automatic test_scan_basic();
    int t3;
    logic [19:0] want;
    want = {5'h05, 5'h02, 5'h08, 5'h05};
    clear_obs();
    drive_seg(slot_an(0), hex_seg[5], 40);
    drive_seg(slot_an(1), hex_seg[2], 40);
    drive_seg(slot_an(2), hex_seg[8], 40);
    t3 = cyc;
    drive_seg(slot_an(3), hex_seg[5], 40);
    checks++; if (obs_g.size() !== exp_g.size()) begin errors++; $display("FAIL scan_count: got %0d want %0d", obs_g.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++) begin
      checks++; if (obs_g[i] !== exp_g[i]) begin errors++; $display("FAIL scan_glyphs[%0d]: got %h want %h", i, obs_g[i], exp_g[i]); end
      checks++; if (obs_c[i] !== exp_c[i]) begin errors++; $display("FAIL scan_changed[%0d]: got %b want %b", i, obs_c[i], exp_c[i]); end
    end
    if (obs_g.size() > 0) begin
      checks++; if (obs_g[0] !== want) begin errors++; $display("FAIL scan_5285: got %h want %h", obs_g[0], want); end
      checks++; if (obs_t[0] !== t3 + S + 2) begin errors++; $display("FAIL scan_latency: got cycle %0d want %0d", obs_t[0], t3 + S + 2); end
    end
    checks++; if (dark !== 1'b0) begin errors++; $display("FAIL scan_dark: got %b want 0", dark); end
    checks++; if (glyphs !== want) begin errors++; $display("FAIL scan_held: got %h want %h", glyphs, want); end
    $display("test_scan_basic: %0d frames", obs_g.size());
  endtask

  task automatic test_repeat();
    clear_obs();
    scan4(hex_seg[5], hex_seg[2], hex_seg[8], hex_seg[5], 40);
    checks++; if (obs_g.size() !== exp_g.size()) begin errors++; $display("FAIL repeat_count: got %0d want %0d", obs_g.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++) begin
      checks++; if (obs_g[i] !== exp_g[i]) begin errors++; $display("FAIL repeat_glyphs[%0d]: got %h want %h", i, obs_g[i], exp_g[i]); end
      checks++; if (obs_c[i] !== exp_c[i]) begin errors++; $display("FAIL repeat_changed[%0d]: got %b want %b", i, obs_c[i], exp_c[i]); end
    end
    $display("test_repeat: %0d frames", obs_g.size());
  endtask

  task automatic test_stable_boundary();
    clear_obs();
    settle();
    scan4(hex_seg[1], hex_seg[3], hex_seg[7], hex_seg[9], 10);
    scan4(hex_seg[4], hex_seg[6], hex_seg[0], hex_seg[2], S - 1);
    checks++; if (obs_g.size() !== 0) begin errors++; $display("FAIL short_hold_frames: got %0d want 0", obs_g.size()); end
    scan4(hex_seg[10], hex_seg[11], hex_seg[12], hex_seg[13], S);
    drive_seg(4'hF, 7'h7F, 4);
    checks++; if (obs_g.size() !== exp_g.size()) begin errors++; $display("FAIL exact_hold_count: got %0d want %0d", obs_g.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++) begin
      checks++; if (obs_g[i] !== exp_g[i]) begin errors++; $display("FAIL exact_hold_glyphs[%0d]: got %h want %h", i, obs_g[i], exp_g[i]); end
      checks++; if (obs_c[i] !== exp_c[i]) begin errors++; $display("FAIL exact_hold_changed[%0d]: got %b want %b", i, obs_c[i], exp_c[i]); end
    end
    $display("test_stable_boundary: %0d frames", obs_g.size());
  endtask

  task automatic test_mux_error();
    logic [3:0] a;
    clear_obs();
    settle();
    drive_seg(4'b0011, hex_seg[$urandom_range(0, 15)], 40);
    checks++; if (obs_mux !== 1) begin errors++; $display("FAIL mux_single: got %0d pulses want 1", obs_mux); end
    for (int k = 0; k < 3; k++) begin
      drive_seg(4'hF, 7'h7F, 20);
      do a = 4'($urandom); while ($countones(~a) < 2);
      drive_seg(a, rand_seg(), $urandom_range(S, 40));
    end
    drive_seg(4'hF, 7'h7F, 4);
    checks++; if (obs_mux !== m_mux) begin errors++; $display("FAIL mux_count: got %0d want %0d", obs_mux, m_mux); end
    checks++; if (obs_g.size() !== 0) begin errors++; $display("FAIL mux_frames: got %0d want 0", obs_g.size()); end
    checks++; if (glyphs !== m_prev) begin errors++; $display("FAIL mux_glyphs: got %h want %h", glyphs, m_prev); end
    $display("test_mux_error: %0d pulses", obs_mux);
  endtask

  task automatic test_random();
    int prev_slot;
    int slot;
    for (int r = 0; r < 4; r++) begin
      clear_obs();
      prev_slot = -1;
      for (int k = 0; k < 12; k++) begin
        do slot = $urandom_range(0, 3); while (slot == prev_slot);
        prev_slot = slot;
        drive_seg(slot_an(slot), rand_seg(), $urandom_range(8, 40));
      end
      settle();
      checks++; if (obs_g.size() !== exp_g.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_g.size(), exp_g.size()); end
      for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++) begin
        checks++; if (obs_g[i] !== exp_g[i]) begin errors++; $display("FAIL rand%0d_glyphs[%0d]: got %h want %h", r, i, obs_g[i], exp_g[i]); end
        checks++; if (obs_c[i] !== exp_c[i]) begin errors++; $display("FAIL rand%0d_changed[%0d]: got %b want %b", r, i, obs_c[i], exp_c[i]); end
      end
      $display("test_random round %0d: %0d frames", r, obs_g.size());
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    scan4(hex_seg[14], hex_seg[15], letter_seg[1], letter_seg[4], 40);
    drive_seg(4'hF, 7'h7F, 450);
    checks++; if (dark !== 1'b0) begin errors++; $display("FAIL timeout_early: got dark=%b want 0", dark); end
    drive_seg(4'hF, 7'h7F, 100);
    checks++; if (dark !== 1'b1) begin errors++; $display("FAIL timeout_dark: got %b want 1", dark); end
    checks++; if (glyphs !== BLANK4) begin errors++; $display("FAIL timeout_glyphs: got %h want %h", glyphs, BLANK4); end
    checks++; if (obs_g.size() !== exp_g.size()) begin errors++; $display("FAIL timeout_frames: got %0d want %0d", obs_g.size(), exp_g.size()); end
    model_reset();
    clear_obs();
    scan4(letter_seg[0], letter_seg[0], letter_seg[0], letter_seg[0], 30);
    drive_seg(4'hF, 7'h7F, 4);
    checks++; if (obs_g.size() !== exp_g.size()) begin errors++; $display("FAIL after_dark_count: got %0d want %0d", obs_g.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++) begin
      checks++; if (obs_g[i] !== exp_g[i]) begin errors++; $display("FAIL after_dark_glyphs[%0d]: got %h want %h", i, obs_g[i], exp_g[i]); end
      checks++; if (obs_c[i] !== exp_c[i]) begin errors++; $display("FAIL after_dark_changed[%0d]: got %b want %b", i, obs_c[i], exp_c[i]); end
    end
    checks++; if (dark !== 1'b0) begin errors++; $display("FAIL after_dark_dark: got %b want 0", dark); end
    $display("test_timeout: done");
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    settle();
    drive_seg(slot_an(0), hex_seg[1], 30);
    drive_seg(slot_an(1), hex_seg[2], 30);
    drive_seg(slot_an(2), hex_seg[3], 30);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (dark !== 1'b1) begin errors++; $display("FAIL midreset_dark: got %b want 1", dark); end
    checks++; if (glyphs !== BLANK4) begin errors++; $display("FAIL midreset_glyphs: got %h want %h", glyphs, BLANK4); end
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    clear_obs();
    drive_seg(slot_an(3), hex_seg[4], 40);
    checks++; if (obs_g.size() !== 0) begin errors++; $display("FAIL midreset_partial: got %0d frames want 0", obs_g.size()); end
    drive_seg(slot_an(0), hex_seg[7], 30);
    drive_seg(slot_an(1), hex_seg[8], 30);
    drive_seg(slot_an(2), hex_seg[9], 30);
    settle();
    checks++; if (obs_g.size() !== exp_g.size()) begin errors++; $display("FAIL midreset_count: got %0d want %0d", obs_g.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++) begin
      checks++; if (obs_g[i] !== exp_g[i]) begin errors++; $display("FAIL midreset_glyphs[%0d]: got %h want %h", i, obs_g[i], exp_g[i]); end
      checks++; if (obs_c[i] !== exp_c[i]) begin errors++; $display("FAIL midreset_changed[%0d]: got %b want %b", i, obs_c[i], exp_c[i]); end
    end
    $display("test_reset_midframe: %0d frames", obs_g.size());
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_repeat();
    test_stable_boundary();
    test_mux_error();
    test_random();
    test_timeout();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
